alu_issue_stage: RTL and testbench

- Decode/issue pipeline stage that drives the ALU's operand1, operand2, funct7 and funct3 inputs, i.e. the initiator side of the ALU interface.
- Accepts one instruction plus register-file read data per valid/ready handshake, decodes RV32I ALU-class instructions and selects operands.
- Applies writeback bypass, then holds the ALU input bundle in a registered output with valid/ready backpressure and flush.
- Sits between the register-file read and the combinational ALU; the ALU result is consumed downstream.

---
 rtl/rv_alu_pkg.sv | 34 +++
 rtl/alu_imm_gen.sv | 15 +
 rtl/alu_issue_stage.sv | 141 ++++++++++++++
 tb/tb_alu_issue_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv_alu_pkg.sv
// Shared RV32I ALU-class encodings and the registered issue bundle type.
package rv_alu_pkg;

    localparam int P_XLEN       = 32;
    localparam int P_REG_ADDR_W = 5;

    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    typedef struct packed {
        logic [P_XLEN-1:0]       operand1;
        logic [P_XLEN-1:0]       operand2;
        logic [6:0]              funct7;
        logic [2:0]              funct3;
        logic [P_REG_ADDR_W-1:0] rd;
        logic                    reg_write;
        logic                    illegal;
    } alu_issue_t;

endpackage

// File: rtl/alu_imm_gen.sv
// Immediate extraction for the ALU-class formats: I-type, shift amount and U-type.
module alu_imm_gen #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] imm_i,
    output logic [XLEN-1:0] imm_shamt,
    output logic [XLEN-1:0] imm_u
);

    assign imm_i     = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_shamt = {{(XLEN-5){1'b0}}, instr[24:20]};
    assign imm_u     = {instr[XLEN-1:12], 12'b0};

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage: decodes RV32I ALU ops, applies writeback bypass and
// holds the ALU input bundle in a valid/ready output register.
module alu_issue_stage
    import rv_alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       instr,
    input  logic [XLEN-1:0]       pc,
    input  logic [XLEN-1:0]       rs1_data,
    input  logic [XLEN-1:0]       rs2_data,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       operand1,
    output logic [XLEN-1:0]       operand2,
    output logic [6:0]            funct7,
    output logic [2:0]            funct3,
    output logic [REG_ADDR_W-1:0] rd,
    output logic                  reg_write,
    output logic                  illegal
);

    logic                  r_valid;
    alu_issue_t            r_bundle;
    alu_issue_t            w_bundle;
    logic                  w_legal;
    logic                  w_capture;
    logic [6:0]            w_opcode;
    logic [6:0]            w_f7;
    logic [2:0]            w_f3;
    logic [REG_ADDR_W-1:0] w_rs1_idx;
    logic [REG_ADDR_W-1:0] w_rs2_idx;
    logic [XLEN-1:0]       w_rs1_val;
    logic [XLEN-1:0]       w_rs2_val;
    logic [XLEN-1:0]       w_imm_i;
    logic [XLEN-1:0]       w_imm_shamt;
    logic [XLEN-1:0]       w_imm_u;

    alu_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr     (instr),
        .imm_i     (w_imm_i),
        .imm_shamt (w_imm_shamt),
        .imm_u     (w_imm_u)
    );

    assign w_opcode  = instr[6:0];
    assign w_f3      = instr[14:12];
    assign w_f7      = instr[31:25];
    assign w_rs1_idx = instr[19:15];
    assign w_rs2_idx = instr[24:20];

    // x0 check first also covers the wb_rd != 0 bypass condition
    assign w_rs1_val = (w_rs1_idx == '0)                   ? '0      :
                       (wb_en && (wb_rd == w_rs1_idx))     ? wb_data : rs1_data;
    assign w_rs2_val = (w_rs2_idx == '0)                   ? '0      :
                       (wb_en && (wb_rd == w_rs2_idx))     ? wb_data : rs2_data;

    always_comb begin
        w_bundle    = '0;
        w_legal     = 1'b0;
        w_bundle.rd = instr[11:7];
        case (w_opcode)
            OP_REG: begin
                w_bundle.operand1 = w_rs1_val;
                w_bundle.operand2 = w_rs2_val;
                w_bundle.funct3   = w_f3;
                w_bundle.funct7   = w_f7;
                w_legal = (w_f7 == F7_BASE) ||
                          ((w_f7 == F7_ALT) && ((w_f3 == F3_ADD_SUB) || (w_f3 == F3_SRL_SRA)));
            end
            OP_IMM: begin
                w_bundle.operand1 = w_rs1_val;
                w_bundle.funct3   = w_f3;
                if ((w_f3 == F3_SLL) || (w_f3 == F3_SRL_SRA)) begin
                    w_bundle.operand2 = w_imm_shamt;
                    w_bundle.funct7   = w_f7;
                    w_legal = (w_f7 == F7_BASE) || ((w_f7 == F7_ALT) && (w_f3 == F3_SRL_SRA));
                end else begin
                    // upper immediate bits must not leak into funct7 (ADDI is never SUB)
                    w_bundle.operand2 = w_imm_i;
                    w_bundle.funct7   = F7_BASE;
                    w_legal = 1'b1;
                end
            end
            OP_LUI: begin
                w_bundle.operand2 = w_imm_u;
                w_legal = 1'b1;
            end
            OP_AUIPC: begin
                w_bundle.operand1 = pc;
                w_bundle.operand2 = w_imm_u;
                w_legal = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
        if (!w_legal) begin
            w_bundle.operand1 = '0;
            w_bundle.operand2 = '0;
            w_bundle.funct3   = '0;
            w_bundle.funct7   = '0;
        end
        w_bundle.illegal   = !w_legal;
        w_bundle.reg_write = w_legal && (w_bundle.rd != '0);
    end

    assign in_ready  = !r_valid || out_ready;
    assign w_capture = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_bundle <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid  <= 1'b1;
            r_bundle <= w_bundle;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign operand1  = r_bundle.operand1;
    assign operand2  = r_bundle.operand2;
    assign funct7    = r_bundle.funct7;
    assign funct3    = r_bundle.funct3;
    assign rd        = r_bundle.rd;
    assign reg_write = r_bundle.reg_write;
    assign illegal   = r_bundle.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode/bypass vector table plus
// backpressure, flush and asynchronous reset sequences.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;

    int checks   = 0;
    int failures = 0;

    alu_issue_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .pc        (pc),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .operand1  (operand1),
        .operand2  (operand2),
        .funct7    (funct7),
        .funct3    (funct3),
        .rd        (rd),
        .reg_write (reg_write),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        wb_en;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic [31:0] e_op1;
        logic [31:0] e_op2;
        logic [6:0]  e_f7;
        logic [2:0]  e_f3;
        logic [4:0]  e_rd;
        logic        e_rw;
        logic        e_ill;
    } vec_t;

    vec_t vecs[17];

    function automatic logic [80:0] exp_bundle(input vec_t v);
        return {v.e_op1, v.e_op2, v.e_f7, v.e_f3, v.e_rd, v.e_rw, v.e_ill};
    endfunction

    function automatic logic [80:0] act_bundle();
        return {operand1, operand2, funct7, funct3, rd, reg_write, illegal};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        instr    = v.instr;
        pc       = v.pc;
        rs1_data = v.rs1;
        rs2_data = v.rs2;
        wb_en    = v.wb_en;
        wb_rd    = v.wb_rd;
        wb_data  = v.wb_data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          instr         pc           rs1          rs2          wbe   wbrd   wbdata       op1          op2          f7     f3    rd     rw    ill
        vecs[0]  = '{32'h002081B3, 32'h0,       32'h5,       32'h7,       1'b0, 5'd0, 32'h0,       32'h5,       32'h7,       7'h00, 3'd0, 5'd3, 1'b1, 1'b0};
        vecs[1]  = '{32'hFFF00093, 32'h0,       32'h1234,    32'h0,       1'b0, 5'd0, 32'h0,       32'h0,       32'hFFFFFFFF, 7'h00, 3'd0, 5'd1, 1'b1, 1'b0};
        vecs[2]  = '{32'h4040D093, 32'h0,       32'h80,      32'h0,       1'b0, 5'd0, 32'h0,       32'h80,      32'h4,       7'h20, 3'd5, 5'd1, 1'b1, 1'b0};
        vecs[3]  = '{32'h40208233, 32'h0,       32'h1,       32'h3,       1'b1, 5'd1, 32'hAA,      32'hAA,      32'h3,       7'h20, 3'd0, 5'd4, 1'b1, 1'b0};
        vecs[4]  = '{32'h40200233, 32'h0,       32'h1,       32'h3,       1'b1, 5'd0, 32'hAA,      32'h0,       32'h3,       7'h20, 3'd0, 5'd4, 1'b1, 1'b0};
        vecs[5]  = '{32'h002081B3, 32'h0,       32'h5,       32'h7,       1'b1, 5'd2, 32'h55,      32'h5,       32'h55,      7'h00, 3'd0, 5'd3, 1'b1, 1'b0};
        vecs[6]  = '{32'h00208463, 32'h0,       32'h5,       32'h7,       1'b0, 5'd0, 32'h0,       32'h0,       32'h0,       7'h00, 3'd0, 5'd8, 1'b0, 1'b1};
        vecs[7]  = '{32'h022081B3, 32'h0,       32'h5,       32'h7,       1'b0, 5'd0, 32'h0,       32'h0,       32'h0,       7'h00, 3'd0, 5'd3, 1'b0, 1'b1};
        vecs[8]  = '{32'h123452B7, 32'h0,       32'h9,       32'h9,       1'b0, 5'd0, 32'h0,       32'h0,       32'h12345000, 7'h00, 3'd0, 5'd5, 1'b1, 1'b0};
        vecs[9]  = '{32'h00001317, 32'h100,     32'h9,       32'h9,       1'b0, 5'd0, 32'h0,       32'h100,     32'h1000,    7'h00, 3'd0, 5'd6, 1'b1, 1'b0};
        vecs[10] = '{32'h00000013, 32'h0,       32'h77,      32'h0,       1'b0, 5'd0, 32'h0,       32'h0,       32'h0,       7'h00, 3'd0, 5'd0, 1'b0, 1'b0};
        vecs[11] = '{32'h4020D3B3, 32'h0,       32'hF0,      32'h2,       1'b0, 5'd0, 32'h0,       32'hF0,      32'h2,       7'h20, 3'd5, 5'd7, 1'b1, 1'b0};
        vecs[12] = '{32'h4020F3B3, 32'h0,       32'hF0,      32'h2,       1'b0, 5'd0, 32'h0,       32'h0,       32'h0,       7'h00, 3'd0, 5'd7, 1'b0, 1'b1};
        vecs[13] = '{32'h40409093, 32'h0,       32'h3,       32'h0,       1'b0, 5'd0, 32'h0,       32'h0,       32'h0,       7'h00, 3'd0, 5'd1, 1'b0, 1'b1};
        vecs[14] = '{32'h80012093, 32'h0,       32'h9,       32'h0,       1'b0, 5'd0, 32'h0,       32'h9,       32'hFFFFF800, 7'h00, 3'd2, 5'd1, 1'b1, 1'b0};
        vecs[15] = '{32'h40014093, 32'h0,       32'h9,       32'h0,       1'b0, 5'd0, 32'h0,       32'h9,       32'h400,     7'h00, 3'd4, 5'd1, 1'b1, 1'b0};
        vecs[16] = '{32'h002081B3, 32'h0,       32'h5,       32'h7,       1'b0, 5'd1, 32'hAA,      32'h5,       32'h7,       7'h00, 3'd0, 5'd3, 1'b1, 1'b0};

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        instr     = '0;
        pc        = '0;
        rs1_data  = '0;
        rs2_data  = '0;
        wb_en     = 1'b0;
        wb_rd     = '0;
        wb_data   = '0;

        #1;
        check("reset_valid", 128'(out_valid), 128'(0));
        check("reset_bundle", 128'(act_bundle()), 128'(0));
        tick();
        tick();
        rst_n = 1'b1;

        // back-to-back table, out_ready held high
        in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i]);
            tick();
            check($sformatf("vec%0d_valid", i), 128'(out_valid), 128'(1));
            check($sformatf("vec%0d_bundle", i), 128'(act_bundle()), 128'(exp_bundle(vecs[i])));
        end
        in_valid = 1'b0;
        tick();
        check("drain_valid", 128'(out_valid), 128'(0));

        // backpressure: hold A for 3 cycles, then release with no bubble
        drive(vecs[0]);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        check("bp_capture", 128'(act_bundle()), 128'(exp_bundle(vecs[0])));
        drive(vecs[8]);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp_in_ready%0d", k), 128'(in_ready), 128'(0));
            check($sformatf("bp_valid%0d", k), 128'(out_valid), 128'(1));
            check($sformatf("bp_hold%0d", k), 128'(act_bundle()), 128'(exp_bundle(vecs[0])));
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 128'(in_ready), 128'(1));
        tick();
        check("bp_next_valid", 128'(out_valid), 128'(1));
        check("bp_next_bundle", 128'(act_bundle()), 128'(exp_bundle(vecs[8])));
        drive(vecs[9]);
        tick();
        check("bp_third_valid", 128'(out_valid), 128'(1));
        check("bp_third_bundle", 128'(act_bundle()), 128'(exp_bundle(vecs[9])));
        in_valid = 1'b0;
        tick();
        check("bp_drain", 128'(out_valid), 128'(0));

        // flush beats an incoming capture
        drive(vecs[3]);
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        check("flush_incoming", 128'(out_valid), 128'(0));
        flush = 1'b0;
        tick();
        check("post_flush_capture", 128'(act_bundle()), 128'(exp_bundle(vecs[3])));
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b1;
        tick();
        check("flush_held", 128'(out_valid), 128'(0));
        flush     = 1'b0;
        out_ready = 1'b1;

        // asynchronous reset while a bundle is held
        drive(vecs[11]);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        check("pre_reset_valid", 128'(out_valid), 128'(1));
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", 128'(out_valid), 128'(0));
        check("async_reset_bundle", 128'(act_bundle()), 128'(0));
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        drive(vecs[2]);
        in_valid = 1'b1;
        tick();
        check("post_reset_valid", 128'(out_valid), 128'(1));
        check("post_reset_bundle", 128'(act_bundle()), 128'(exp_bundle(vecs[2])));
        in_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
